// File: rtl/gcm_block_sequencer.sv
// gcm_block_sequencer
// Per-instance GCM block sequencer. Takes one header (IV, AAD and text bit
// lengths), then streams the AAD and text blocks through a single output
// register and finishes each instance with the len(A)||len(C) block.
// Every emitted block is tagged with its phase code, its index within the
// phase, its CTR counter block and a byte-valid mask.
//
// Optional feature: define GCM_PARTIAL_BLOCK_EN to round block counts up
// and to generate byte masks for partial final blocks. Without it, block
// counts are len >> 7 and the mask is always all ones.

module gcm_block_sequencer #(
    parameter int BLOCK_W = 128,
    parameter int LEN_W   = 64,
    parameter int IV_W    = 96,
    parameter int IDX_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    output logic                 o_start_rdy,
    input  logic [LEN_W-1:0]     i_aad_len,
    input  logic [LEN_W-1:0]     i_txt_len,
    input  logic [IV_W-1:0]      i_iv,
    input  logic                 i_blk_vld,
    output logic                 o_blk_rdy,
    input  logic [BLOCK_W-1:0]   i_blk,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic [BLOCK_W-1:0]   o_blk,
    output logic [2:0]           o_phase,
    output logic [127:0]         o_ctr,
    output logic [IDX_W-1:0]     o_blk_idx,
    output logic [BLOCK_W/8-1:0] o_mask,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int MASK_W = BLOCK_W / 8;

    // Largest text block count whose counters (2 .. nT+1) do not wrap into J0.
    localparam logic [LEN_W-1:0] NT_MAX = LEN_W'(64'h0000_0000_FFFF_FFFE);

    localparam logic [2:0] PH_AAD      = 3'b010;
    localparam logic [2:0] PH_TXT_FRST = 3'b000;
    localparam logic [2:0] PH_TXT_MID  = 3'b001;
    localparam logic [2:0] PH_TXT_LAST = 3'b011;
    localparam logic [2:0] PH_TXT_ONLY = 3'b111;
    localparam logic [2:0] PH_LEN      = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AAD  = 2'd1,
        S_TXT  = 2'd2,
        S_LEN  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Number of 128-bit blocks covered by a bit length.
    function automatic logic [LEN_W-1:0] blk_count(input logic [LEN_W-1:0] len);
`ifdef GCM_PARTIAL_BLOCK_EN
        return (len >> 7) + LEN_W'(len[6:0] != 7'd0);
`else
        return len >> 7;
`endif
    endfunction

`ifdef GCM_PARTIAL_BLOCK_EN
    // Byte mask of a final block: leading ceil((len mod 128)/8) bytes, MSB = byte 0.
    function automatic logic [MASK_W-1:0] last_mask(input logic [LEN_W-1:0] len);
        logic [7:0] nbytes;
        nbytes = (8'(len[6:0]) + 8'd7) >> 3;
        if (len[6:0] == 7'd0) begin
            return '1;
        end
        return ~({MASK_W{1'b1}} >> nbytes);
    endfunction
`endif

    // Latched instance header
    logic [LEN_W-1:0] aad_len_q;
    logic [LEN_W-1:0] txt_len_q;
    logic [IV_W-1:0]  iv_q;
    logic [LEN_W-1:0] na_q;
    logic [LEN_W-1:0] nt_q;

    // Block index within the current phase
    logic [LEN_W-1:0] blk_cnt;
    logic             cnt_clr;
    logic             cnt_inc;

    // Len block has been placed in the output register
    logic             len_loaded;

    logic [LEN_W-1:0] na_in;
    logic [LEN_W-1:0] nt_in;
    logic             hdr_acc;
    logic             hdr_bad;
    logic             reg_free;
    logic             blk_hs;
    logic             last_blk;
    logic [LEN_W-1:0] phase_n;
    logic             len_load;
    logic             len_done;

    logic [2:0]        d_phase;
    logic [127:0]      d_ctr;
    logic [MASK_W-1:0] d_mask;
    logic [31:0]       ctr_lo;

    assign na_in    = blk_count(i_aad_len);
    assign nt_in    = blk_count(i_txt_len);
    assign hdr_acc  = i_start && o_start_rdy;
    assign hdr_bad  = nt_in > NT_MAX;

    assign reg_free    = !o_vld || i_rdy;
    assign o_start_rdy = (state == S_IDLE);
    assign o_blk_rdy   = ((state == S_AAD) || (state == S_TXT)) && reg_free;
    assign o_busy      = (state != S_IDLE) || o_vld;

    assign blk_hs   = i_blk_vld && o_blk_rdy;
    assign phase_n  = (state == S_AAD) ? na_q : nt_q;
    assign last_blk = (blk_cnt == phase_n - LEN_W'(1));
    assign len_load = (state == S_LEN) && !len_loaded && reg_free;
    assign len_done = (state == S_LEN) && len_loaded && o_vld && i_rdy;

    // State register
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and block-counter control
    // NOTE: each signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (hdr_acc && !hdr_bad) begin
                    cnt_clr = 1'b1;
                    if (na_in != '0) begin
                        state_nxt = S_AAD;
                    end else if (nt_in != '0) begin
                        state_nxt = S_TXT;
                    end else begin
                        state_nxt = S_LEN;
                    end
                end
            end
            S_AAD: begin
                if (blk_hs) begin
                    if (last_blk) begin
                        cnt_clr   = 1'b1;
                        state_nxt = (nt_q != '0) ? S_TXT : S_LEN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_TXT: begin
                if (blk_hs) begin
                    if (last_blk) begin
                        cnt_clr   = 1'b1;
                        state_nxt = S_LEN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_LEN: begin
                if (len_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Tag fields for the data block currently being accepted
    always_comb begin
        d_phase = PH_AAD;
        d_ctr   = '0;
        d_mask  = '1;
        ctr_lo  = blk_cnt[31:0] + 32'd2;
        if (state == S_TXT) begin
            d_ctr = {iv_q, ctr_lo};
            if (nt_q == LEN_W'(1)) begin
                d_phase = PH_TXT_ONLY;
            end else if (blk_cnt == '0) begin
                d_phase = PH_TXT_FRST;
            end else if (last_blk) begin
                d_phase = PH_TXT_LAST;
            end else begin
                d_phase = PH_TXT_MID;
            end
        end
`ifdef GCM_PARTIAL_BLOCK_EN
        if (last_blk) begin
            d_mask = last_mask((state == S_TXT) ? txt_len_q : aad_len_q);
        end
`endif
    end

    // Header latch and sticky oversize error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aad_len_q <= '0;
            txt_len_q <= '0;
            iv_q      <= '0;
            na_q      <= '0;
            nt_q      <= '0;
            o_err     <= 1'b0;
        end else if (hdr_acc) begin
            if (hdr_bad) begin
                o_err <= 1'b1;
            end else begin
                aad_len_q <= i_aad_len;
                txt_len_q <= i_txt_len;
                iv_q      <= i_iv;
                na_q      <= na_in;
                nt_q      <= nt_in;
            end
        end
    end

    // Per-phase block counter and len-block bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt    <= '0;
            len_loaded <= 1'b0;
        end else begin
            if (cnt_clr) begin
                blk_cnt <= '0;
            end else if (cnt_inc) begin
                blk_cnt <= blk_cnt + LEN_W'(1);
            end
            if (len_load) begin
                len_loaded <= 1'b1;
            end else if (len_done) begin
                len_loaded <= 1'b0;
            end
        end
    end

    // Single-entry output register: loads on an input handshake or with the
    // len block, holds while stalled, empties on a downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld     <= 1'b0;
            o_blk     <= '0;
            o_phase   <= '0;
            o_ctr     <= '0;
            o_blk_idx <= '0;
            o_mask    <= '0;
        end else if (blk_hs) begin
            o_vld     <= 1'b1;
            o_blk     <= i_blk;
            o_phase   <= d_phase;
            o_ctr     <= d_ctr;
            o_blk_idx <= blk_cnt[IDX_W-1:0];
            o_mask    <= d_mask;
        end else if (len_load) begin
            o_vld     <= 1'b1;
            o_blk     <= {aad_len_q, txt_len_q};
            o_phase   <= PH_LEN;
            o_ctr     <= {iv_q, 32'h0000_0001};
            o_blk_idx <= '0;
            o_mask    <= '1;
        end else if (i_rdy) begin
            o_vld <= 1'b0;
        end
    end

endmodule
